// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and default widths for the memory stage controller.
//   AddrW / DataW : default data-memory word-address width and word width
//   state_e       : sequencer state (single-word cycle or second word of CALL/RET)
//   sp_op_e       : stack-pointer update selected by the sequencer
package mem_stage_ctrl_pkg;

  localparam int unsigned AddrW = 12;
  localparam int unsigned DataW = 16;

  typedef enum logic {
    StIdle,
    StWord2
  } state_e;

  typedef enum logic [2:0] {
    SpHold,
    SpInc1,
    SpDec1,
    SpInc2,
    SpDec2
  } sp_op_e;

endpackage

// File: rtl/mem_stage_ctrl_stack_pointer_unit.sv
// Stack pointer register with +1/-1/+2/-2 updates and a sticky wrap fault.
//   clk, reset            : clock, asynchronous active-low reset (SP resets to all ones)
//   op                    : update to apply at the next rising edge
//   sp                    : current SP
//   sp_plus1/2, sp_minus1 : precomputed neighbour addresses (modulo 2^ADDR_W)
//   fault                 : set when an update wraps, cleared only by reset
module mem_stage_ctrl_stack_pointer_unit
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  sp_op_e            op,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_plus1,
  output logic [ADDR_W-1:0] sp_plus2,
  output logic [ADDR_W-1:0] sp_minus1,
  output logic              fault
);

  logic [ADDR_W-1:0] sp_q, sp_d, sp_minus2;
  logic              fault_q, wrap;

  assign sp_plus1  = sp_q + ADDR_W'(1);
  assign sp_plus2  = sp_q + ADDR_W'(2);
  assign sp_minus1 = sp_q - ADDR_W'(1);
  assign sp_minus2 = sp_q - ADDR_W'(2);

  // A wrap is detected by the result moving the "wrong" way past the modulus.
  always_comb begin
    sp_d = sp_q;
    wrap = 1'b0;
    unique case (op)
      SpInc1: begin sp_d = sp_plus1;  wrap = (sp_plus1 < sp_q);  end
      SpDec1: begin sp_d = sp_minus1; wrap = (sp_minus1 > sp_q); end
      SpInc2: begin sp_d = sp_plus2;  wrap = (sp_plus2 < sp_q);  end
      SpDec2: begin sp_d = sp_minus2; wrap = (sp_minus2 > sp_q); end
      SpHold: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q    <= '1;
      fault_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      fault_q <= fault_q | wrap;
    end
  end

  assign sp    = sp_q;
  assign fault = fault_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: data loads/stores, single-word push/pop via SP, and two-cycle
// 32-bit PC push (CALL/INT) and pop (RET). Results are registered into MEM/WB.
//   clk, reset                 : clock, asynchronous active-low reset
//   EX/MEM inputs              : mem_read/mem_write/stack_or_data/pc_to_stack/ret/inc_dec_sp,
//                                register_write/mem_to_register/in_port/read_addr,
//                                alu_result/read_data_2/IN_PORT/pc
//   mem_addr/mem_we/mem_wdata  : combinational data-memory request
//   mem_rdata                  : asynchronous read data for mem_addr
//   stall                      : hold upstream during the first word of CALL/RET
//   wb_*                       : MEM/WB pipeline register
//   pc_load, pc_load_value     : one-cycle pulse carrying the popped return PC
//   sp_fault                   : sticky stack overflow/underflow
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              stack_or_data,
  input  logic              pc_to_stack,
  input  logic              ret,
  input  logic              inc_dec_sp,
  input  logic              register_write,
  input  logic              mem_to_register,
  input  logic              in_port,
  input  logic [2:0]        read_addr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] IN_PORT,
  input  logic [31:0]       pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              wb_register_write,
  output logic              wb_mem_to_register,
  output logic              wb_in_port,
  output logic [2:0]        wb_read_addr,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_IN_PORT,
  output logic              pc_load,
  output logic [31:0]       pc_load_value,
  output logic              sp_fault
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] lat_q, lat_d;     // low word carried between the two cycles
  logic              is_ret_q, is_ret_d;
  logic              bubble;
  logic              pc_load_q, pc_load_d;
  logic [31:0]       pc_load_value_q, pc_load_value_d;
  sp_op_e            sp_op;
  logic [ADDR_W-1:0] sp, sp_plus1, sp_plus2, sp_minus1;

  logic              wb_register_write_q, wb_mem_to_register_q, wb_in_port_q;
  logic [2:0]        wb_read_addr_q;
  logic [DATA_W-1:0] wb_mem_data_q, wb_alu_result_q, wb_IN_PORT_q;

  mem_stage_ctrl_stack_pointer_unit #(
    .ADDR_W(ADDR_W)
  ) u_sp (
    .clk      (clk),
    .reset    (reset),
    .op       (sp_op),
    .sp       (sp),
    .sp_plus1 (sp_plus1),
    .sp_plus2 (sp_plus2),
    .sp_minus1(sp_minus1),
    .fault    (sp_fault)
  );

  always_comb begin
    state_d         = state_q;
    lat_d           = lat_q;
    is_ret_d        = is_ret_q;
    mem_addr        = alu_result[ADDR_W-1:0];
    mem_we          = 1'b0;
    mem_wdata       = read_data_2;
    stall           = 1'b0;
    sp_op           = SpHold;
    bubble          = 1'b0;
    pc_load_d       = 1'b0;
    pc_load_value_d = pc_load_value_q;
    unique case (state_q)
      StIdle: begin
        if (pc_to_stack) begin
          mem_addr  = sp;
          mem_we    = 1'b1;
          mem_wdata = pc[31:16];
          lat_d     = pc[15:0];
          is_ret_d  = 1'b0;
          stall     = 1'b1;
          bubble    = 1'b1;
          state_d   = StWord2;
        end else if (ret) begin
          mem_addr = sp_plus1;
          lat_d    = mem_rdata;
          is_ret_d = 1'b1;
          stall    = 1'b1;
          bubble   = 1'b1;
          state_d  = StWord2;
        end else if ((mem_write || mem_read) && stack_or_data) begin
          mem_we = mem_write;
          if (inc_dec_sp) begin
            mem_addr = sp_plus1;
            sp_op    = SpInc1;
          end else begin
            mem_addr = sp;
            sp_op    = SpDec1;
          end
        end else begin
          mem_we = mem_write;
        end
      end
      StWord2: begin
        // Upstream replays the same instruction here, so EX/MEM inputs are ignored.
        bubble  = 1'b1;
        state_d = StIdle;
        if (is_ret_q) begin
          mem_addr        = sp_plus2;
          sp_op           = SpInc2;
          pc_load_d       = 1'b1;
          pc_load_value_d = {mem_rdata, lat_q};
        end else begin
          mem_addr  = sp_minus1;
          mem_we    = 1'b1;
          mem_wdata = lat_q;
          sp_op     = SpDec2;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      lat_q           <= '0;
      is_ret_q        <= 1'b0;
      pc_load_q       <= 1'b0;
      pc_load_value_q <= '0;
    end else begin
      state_q         <= state_d;
      lat_q           <= lat_d;
      is_ret_q        <= is_ret_d;
      pc_load_q       <= pc_load_d;
      pc_load_value_q <= pc_load_value_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bubble) begin
      wb_register_write_q  <= 1'b0;
      wb_mem_to_register_q <= 1'b0;
      wb_in_port_q         <= 1'b0;
      wb_read_addr_q       <= '0;
      wb_mem_data_q        <= '0;
      wb_alu_result_q      <= '0;
      wb_IN_PORT_q         <= '0;
    end else begin
      wb_register_write_q  <= register_write;
      wb_mem_to_register_q <= mem_to_register;
      wb_in_port_q         <= in_port;
      wb_read_addr_q       <= read_addr;
      wb_mem_data_q        <= mem_rdata;
      wb_alu_result_q      <= alu_result;
      wb_IN_PORT_q         <= IN_PORT;
    end
  end

  assign wb_register_write  = wb_register_write_q;
  assign wb_mem_to_register = wb_mem_to_register_q;
  assign wb_in_port         = wb_in_port_q;
  assign wb_read_addr       = wb_read_addr_q;
  assign wb_mem_data        = wb_mem_data_q;
  assign wb_alu_result      = wb_alu_result_q;
  assign wb_IN_PORT         = wb_IN_PORT_q;
  assign pc_load            = pc_load_q;
  assign pc_load_value      = pc_load_value_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, stack_or_data, pc_to_stack, ret, inc_dec_sp;
  logic        register_write, mem_to_register, in_port;
  logic [2:0]  read_addr;
  logic [15:0] alu_result, read_data_2, IN_PORT;
  logic [31:0] pc;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;
  logic        stall;
  logic        wb_register_write, wb_mem_to_register, wb_in_port;
  logic [2:0]  wb_read_addr;
  logic [15:0] wb_mem_data, wb_alu_result, wb_IN_PORT;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic        sp_fault;

  // Environment memory and reference model state
  logic [15:0] mem [DEPTH];
  logic [15:0] exp_mem [DEPTH];
  logic        mem_init = 1'b0;
  int          sp_m;
  bit          fault_m;
  int          n_vec = 0;
  int          n_err = 0;

  mem_stage_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .stack_or_data     (stack_or_data),
    .pc_to_stack       (pc_to_stack),
    .ret               (ret),
    .inc_dec_sp        (inc_dec_sp),
    .register_write    (register_write),
    .mem_to_register   (mem_to_register),
    .in_port           (in_port),
    .read_addr         (read_addr),
    .alu_result        (alu_result),
    .read_data_2       (read_data_2),
    .IN_PORT           (IN_PORT),
    .pc                (pc),
    .mem_addr          (mem_addr),
    .mem_we            (mem_we),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .stall             (stall),
    .wb_register_write (wb_register_write),
    .wb_mem_to_register(wb_mem_to_register),
    .wb_in_port        (wb_in_port),
    .wb_read_addr      (wb_read_addr),
    .wb_mem_data       (wb_mem_data),
    .wb_alu_result     (wb_alu_result),
    .wb_IN_PORT        (wb_IN_PORT),
    .pc_load           (pc_load),
    .pc_load_value     (pc_load_value),
    .sp_fault          (sp_fault)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or posedge mem_init) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'(i * 40503) ^ 16'h5A5A;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic clear_inputs();
    {mem_read, mem_write, stack_or_data, pc_to_stack, ret, inc_dec_sp} = '0;
    {register_write, mem_to_register, in_port} = '0;
    read_addr = '0; alu_result = '0; read_data_2 = '0; IN_PORT = '0; pc = '0;
  endtask

  task automatic drive_garbage();
    {mem_read, mem_write, stack_or_data, pc_to_stack, ret, inc_dec_sp,
     register_write, mem_to_register, in_port} = 9'($urandom);
    read_addr   = 3'($urandom);
    alu_result  = 16'($urandom);
    read_data_2 = 16'($urandom);
    IN_PORT     = 16'($urandom);
    pc          = $urandom;
  endtask

  // Returns at a falling edge with SP and fault back at their reset values.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    sp_m    = DEPTH - 1;
    fault_m = 1'b0;
  endtask

  // kind: 0 none, 1 store, 2 load, 3 push, 4 pop, 5 CALL, 6 RET. Starts and ends at a falling edge.
  task automatic run_op(input int kind, input logic [15:0] alu, input logic [15:0] d,
                        input logic [31:0] pcv, input logic [2:0] ra, input logic rw,
                        input logic m2r, input logic inp, input logic [15:0] inport);
    int          addr, addr2, nsp;
    logic [15:0] rdata, hi, lo;
    bit          exp_we;
    clear_inputs();
    register_write = rw; mem_to_register = m2r; in_port = inp; read_addr = ra;
    alu_result = alu; read_data_2 = d; IN_PORT = inport; pc = pcv;
    inc_dec_sp = 1'($urandom);
    case (kind)
      0: stack_or_data = 1'($urandom);
      1: mem_write = 1'b1;
      2: mem_read = 1'b1;
      3: begin mem_write = 1'b1; stack_or_data = 1'b1; inc_dec_sp = 1'b0; end
      4: begin mem_read = 1'b1; stack_or_data = 1'b1; inc_dec_sp = 1'b1; end
      5: begin pc_to_stack = 1'b1; ret = 1'($urandom); mem_write = 1'($urandom);
               mem_read = 1'($urandom); stack_or_data = 1'($urandom); end
      default: begin ret = 1'b1; mem_write = 1'($urandom); mem_read = 1'($urandom);
               stack_or_data = 1'($urandom); end
    endcase
    case (kind)
      3, 5:    addr = sp_m;
      4, 6:    addr = (sp_m + 1) % DEPTH;
      default: addr = int'(alu[11:0]);
    endcase
    exp_we = (kind == 1 || kind == 3 || kind == 5);
    #1;
    n_vec++;
    if (mem_addr !== 12'(addr)) begin
      n_err++; $display("FAIL addr kind=%0d: mem_addr got %h want %h", kind, mem_addr, 12'(addr));
    end
    n_vec++;
    if (mem_we !== exp_we || stall !== (kind >= 5)) begin
      n_err++; $display("FAIL strobe kind=%0d: we/stall got %b%b want %b%b",
                        kind, mem_we, stall, exp_we, kind >= 5);
    end
    if (exp_we) begin
      n_vec++;
      if (mem_wdata !== ((kind == 5) ? pcv[31:16] : d)) begin
        n_err++; $display("FAIL wdata kind=%0d: got %h want %h", kind, mem_wdata,
                          (kind == 5) ? pcv[31:16] : d);
      end
    end
    rdata = exp_mem[addr];
    lo    = rdata;
    if (exp_we) exp_mem[addr] = (kind == 5) ? pcv[31:16] : d;
    @(posedge clk); #1;
    if (kind < 5) begin
      if (kind == 3) begin fault_m |= (sp_m == 0);         sp_m = (sp_m + DEPTH - 1) % DEPTH; end
      if (kind == 4) begin fault_m |= (sp_m == DEPTH - 1); sp_m = (sp_m + 1) % DEPTH; end
      n_vec++;
      if ({wb_register_write, wb_mem_to_register, wb_in_port, wb_read_addr} !== {rw, m2r, inp, ra}) begin
        n_err++; $display("FAIL wb_ctrl kind=%0d: got %b want %b", kind,
          {wb_register_write, wb_mem_to_register, wb_in_port, wb_read_addr}, {rw, m2r, inp, ra});
      end
      n_vec++;
      if (wb_mem_data !== rdata || wb_alu_result !== alu || wb_IN_PORT !== inport) begin
        n_err++; $display("FAIL wb_data kind=%0d: got %h/%h/%h want %h/%h/%h", kind,
          wb_mem_data, wb_alu_result, wb_IN_PORT, rdata, alu, inport);
      end
      n_vec++;
      if (pc_load !== 1'b0) begin
        n_err++; $display("FAIL pc_load_idle kind=%0d: got %b want 0", kind, pc_load);
      end
    end else begin
      n_vec++;
      if (wb_register_write !== 1'b0) begin
        n_err++; $display("FAIL bubble1 kind=%0d: wb_register_write got %b want 0",
                          kind, wb_register_write);
      end
      @(negedge clk);
      drive_garbage();
      addr2 = (kind == 5) ? (sp_m + DEPTH - 1) % DEPTH : (sp_m + 2) % DEPTH;
      #1;
      n_vec++;
      if (mem_addr !== 12'(addr2) || stall !== 1'b0 || mem_we !== (kind == 5)) begin
        n_err++; $display("FAIL word2 kind=%0d: addr/stall/we got %h/%b/%b want %h/0/%b",
                          kind, mem_addr, stall, mem_we, 12'(addr2), kind == 5);
      end
      if (kind == 5) begin
        n_vec++;
        if (mem_wdata !== pcv[15:0]) begin
          n_err++; $display("FAIL word2_wdata: got %h want %h", mem_wdata, pcv[15:0]);
        end
      end
      hi = exp_mem[addr2];
      if (kind == 5) exp_mem[addr2] = pcv[15:0];
      nsp = (kind == 5) ? sp_m - 2 : sp_m + 2;
      if (nsp < 0 || nsp >= DEPTH) fault_m = 1'b1;
      sp_m = (nsp + DEPTH) % DEPTH;
      @(posedge clk); #1;
      n_vec++;
      if (wb_register_write !== 1'b0 || pc_load !== (kind == 6)) begin
        n_err++; $display("FAIL word2_out kind=%0d: wb_rw/pc_load got %b%b want 0%b",
                          kind, wb_register_write, pc_load, kind == 6);
      end
      if (kind == 6) begin
        n_vec++;
        if (pc_load_value !== {hi, lo}) begin
          n_err++; $display("FAIL pc_load_value: got %h want %h", pc_load_value, {hi, lo});
        end
      end
    end
    n_vec++;
    if (sp_fault !== fault_m) begin
      n_err++; $display("FAIL sp_fault kind=%0d: got %b want %b", kind, sp_fault, fault_m);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    // Still inside the power-on reset
    n_vec++;
    if ({wb_register_write, wb_mem_to_register, wb_in_port, wb_read_addr, wb_mem_data,
         wb_alu_result, wb_IN_PORT, pc_load, pc_load_value, sp_fault} !== '0) begin
      n_err++; $display("FAIL reset_outputs: registered outputs not all zero");
    end
    reset = 1'b1; sp_m = DEPTH - 1; fault_m = 1'b0;
    run_op(0, 16'h1234, 16'h0, 32'h0, 3'd5, 1'b1, 1'b1, 1'b1, 16'h7777);
    run_op(4, 16'h0, 16'h0, 32'h0, 3'd1, 1'b1, 1'b1, 1'b0, 16'h0);     // pop at top: fault
    run_op(3, 16'h0, 16'h4242, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);  // push at 0: fault
    // Reset during the second word of a CALL
    clear_inputs();
    pc_to_stack = 1'b1; pc = 32'hABCD_1234;
    @(posedge clk); #1;
    exp_mem[sp_m] = 16'hABCD;
    reset = 1'b0;
    clear_inputs();
    #1;
    n_vec++;
    if (mem_we !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL reset_midcall_strobe: we/stall got %b%b want 00", mem_we, stall);
    end
    n_vec++;
    if ({wb_register_write, wb_mem_to_register, wb_in_port, wb_read_addr, wb_mem_data,
         wb_alu_result, wb_IN_PORT, pc_load, sp_fault} !== '0) begin
      n_err++; $display("FAIL reset_midcall_wb: outputs not zero, sp_fault=%b", sp_fault);
    end
    @(negedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1; sp_m = DEPTH - 1; fault_m = 1'b0;
    n_vec++;
    if (mem[12'hFFE] !== exp_mem[12'hFFE] || mem[12'hFFF] !== 16'hABCD) begin
      n_err++; $display("FAIL reset_midcall_mem: FFE/FFF got %h/%h want %h/abcd",
                        mem[12'hFFE], mem[12'hFFF], exp_mem[12'hFFE]);
    end
    // Push address confirms SP is back at FFF
    run_op(3, 16'h0, 16'h5555, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    run_op(4, 16'h0, 16'h0, 32'h0, 3'd3, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic test_store();
    run_op(1, 16'h0034, 16'hBEEF, 32'h0, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0);
    n_vec++;
    if (mem[12'h034] !== 16'hBEEF) begin
      n_err++; $display("FAIL store_mem: mem[034] got %h want beef", mem[12'h034]);
    end
    run_op(2, 16'h0034, 16'h0, 32'h0, 3'd6, 1'b1, 1'b1, 1'b0, 16'h0);
    n_vec++;
    if (wb_mem_data !== 16'hBEEF) begin
      n_err++; $display("FAIL load_back: wb_mem_data got %h want beef", wb_mem_data);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    run_op(3, 16'h0, 16'h1111, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    n_vec++;
    if (mem[12'hFFF] !== 16'h1111) begin
      n_err++; $display("FAIL push_mem: mem[FFF] got %h want 1111", mem[12'hFFF]);
    end
    run_op(4, 16'h0, 16'h0, 32'h0, 3'd2, 1'b1, 1'b1, 1'b0, 16'h0);
    n_vec++;
    if (wb_read_addr !== 3'd2 || wb_mem_data !== 16'h1111) begin
      n_err++; $display("FAIL pop_wb: rd/data got %0d/%h want 2/1111", wb_read_addr, wb_mem_data);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    run_op(5, 16'h0, 16'h0, 32'h0001_0200, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0);
    n_vec++;
    if (mem[12'hFFF] !== 16'h0001 || mem[12'hFFE] !== 16'h0200) begin
      n_err++; $display("FAIL call_mem: FFF/FFE got %h/%h want 0001/0200",
                        mem[12'hFFF], mem[12'hFFE]);
    end
    run_op(6, 16'h0, 16'h0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0);
    n_vec++;
    if (pc_load !== 1'b1 || pc_load_value !== 32'h0001_0200) begin
      n_err++; $display("FAIL ret_pc: pc_load/value got %b/%h want 1/00010200",
                        pc_load, pc_load_value);
    end
    // pc_load must drop after one cycle; SP back at FFF shows as push address
    run_op(3, 16'h0, 16'h9999, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_underflow();
    do_reset();
    run_op(4, 16'h0, 16'h0, 32'h0, 3'd1, 1'b1, 1'b1, 1'b0, 16'h0);
    n_vec++;
    if (sp_fault !== 1'b1) begin
      n_err++; $display("FAIL underflow_fault: got %b want 1", sp_fault);
    end
    run_op(0, 16'h0ABC, 16'h0, 32'h0, 3'd1, 1'b1, 1'b0, 1'b1, 16'h3333);
    run_op(3, 16'h0, 16'h2222, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    n_vec++;
    if (sp_fault !== 1'b1) begin
      n_err++; $display("FAIL fault_sticky: got %b want 1", sp_fault);
    end
  endtask

  task automatic test_random();
    int kind, bad;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: kind = 0;
        1: kind = 1;
        2: kind = 2;
        3, 4: kind = 3;
        5, 6: kind = 4;
        7: kind = 5;
        8: kind = 6;
        default: kind = $urandom_range(0, 6);
      endcase
      run_op(kind, 16'($urandom), 16'($urandom), $urandom, 3'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 16'($urandom));
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL memory_image: %0d words differ, want 0", bad);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
    #1 mem_init = 1'b1;
    #1 mem_init = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_store();
    test_push_pop();
    test_call_ret();
    test_underflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
